// File: rtl/register_file_sb.sv
// Parametrised register file: two combinational read ports, two prioritised
// synchronous write ports, optional zero register and write-to-read bypass, and a per-register pending bit.
module register_file_sb #(
    parameter int N        = 8,
    parameter int M        = 3,
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] ra1,
    input  logic [M-1:0] ra2,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2,
    output logic         rdy1,
    output logic         rdy2,
    input  logic         we3,
    input  logic [M-1:0] wa3,
    input  logic [N-1:0] wd3,
    input  logic         we4,
    input  logic [M-1:0] wa4,
    input  logic [N-1:0] wd4,
    input  logic         alloc,
    input  logic [M-1:0] aa
);
    localparam int DEPTH = 1 << M;

    logic [N-1:0]     regs_reg [DEPTH];
    logic [DEPTH-1:0] pend_reg;
    logic [DEPTH-1:0] pend_next;
    logic [DEPTH-1:0] hit3;
    logic [DEPTH-1:0] hit4;
    logic [DEPTH-1:0] hit_alloc;

    // One-hot decode per register; the zero register never sees a hit.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dec
            localparam logic [M-1:0] ADDR     = M'(gi);
            localparam bit           WRITABLE = !(ZERO_REG && (gi == 0));
            assign hit3[gi]      = WRITABLE && we3 && (wa3 == ADDR);
            assign hit4[gi]      = WRITABLE && we4 && (wa4 == ADDR);
            assign hit_alloc[gi] = WRITABLE && alloc && (aa == ADDR);
        end
    endgenerate

    // A same-cycle alloc wins over the write's clear: the new producer is still outstanding.
    assign pend_next = hit_alloc | (pend_reg & ~(hit3 | hit4));

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            pend_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit4[i]) begin
                    regs_reg[i] <= wd4;
                end else if (hit3[i]) begin
                    regs_reg[i] <= wd3;
                end
            end
            pend_reg <= pend_next;
        end
    end

    // Returns {rdy, data} for one read address.
    function automatic logic [N:0] read_port(input logic [M-1:0] ra);
        logic [N:0] r;
        r = {~pend_reg[ra], regs_reg[ra]};
        if (ZERO_REG && (ra == '0)) begin
            r = {1'b1, {N{1'b0}}};
        end else if (BYPASS && we4 && (wa4 == ra)) begin
            r = {1'b1, wd4};
        end else if (BYPASS && we3 && (wa3 == ra)) begin
            r = {1'b1, wd3};
        end
        return r;
    endfunction

    always_comb begin
        {rdy1, rd1} = read_port(ra1);
        {rdy2, rd2} = read_port(ra2);
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: three instances (plain, bypass, bypass+zero register)
// share stimulus and are checked against an array-based model of the register file.
module tb_register_file_sb;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ra1, ra2, wa3, wa4, aa;
    logic [7:0] wd3, wd4;
    logic       we3, we4, alloc;

    logic [7:0] rd1_w  [3];
    logic [7:0] rd2_w  [3];
    logic       rdy1_w [3];
    logic       rdy2_w [3];

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = ordinary register file, index 1 = zero-register variant.
    logic [7:0] mem  [2][8];
    bit         pend [2][8];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            register_file_sb #(
                .N(8), .M(3), .ZERO_REG(gi == 2), .BYPASS(gi != 0)
            ) dut (
                .clk(clk), .rst(rst),
                .ra1(ra1), .ra2(ra2),
                .rd1(rd1_w[gi]), .rd2(rd2_w[gi]),
                .rdy1(rdy1_w[gi]), .rdy2(rdy2_w[gi]),
                .we3(we3), .wa3(wa3), .wd3(wd3),
                .we4(we4), .wa4(wa4), .wd4(wd4),
                .alloc(alloc), .aa(aa)
            );
        end
    endgenerate

    function automatic logic [8:0] obs(input int d, input int port);
        return (port == 1) ? {rdy1_w[d], rd1_w[d]} : {rdy2_w[d], rd2_w[d]};
    endfunction

    // Expected {rdy, data} for instance d reading address ra in the current cycle.
    function automatic logic [8:0] exp_read(input int d, input logic [2:0] ra);
        int z;
        z = (d == 2) ? 1 : 0;
        if (z == 1 && ra == 3'd0) return 9'h100;
        if (d != 0 && we4 && wa4 == ra) return {1'b1, wd4};
        if (d != 0 && we3 && wa3 == ra) return {1'b1, wd3};
        return {~pend[z][ra], mem[z][ra]};
    endfunction

    task automatic idle();
        we3 = 0; we4 = 0; alloc = 0;
        wa3 = 0; wa4 = 0; aa = 0; wd3 = 0; wd4 = 0;
    endtask

    // Advance one edge; the model applies port 3, then port 4 (overwrites), then alloc.
    task automatic tick();
        @(posedge clk);
        for (int z = 0; z < 2; z++) begin
            if (!rst) begin
                for (int a = 0; a < 8; a++) begin
                    mem[z][a] = 8'h00;
                    pend[z][a] = 0;
                end
            end else begin
                if (we3 && !(z == 1 && wa3 == 0)) begin
                    mem[z][wa3] = wd3; pend[z][wa3] = 0;
                end
                if (we4 && !(z == 1 && wa4 == 0)) begin
                    mem[z][wa4] = wd4; pend[z][wa4] = 0;
                end
                if (alloc && !(z == 1 && aa == 0)) pend[z][aa] = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 0; idle(); ra1 = 0; ra2 = 0;
        tick(); tick();
        rst = 1; ra1 = 3'd1; ra2 = 3'd7;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h100) begin
                errors++; $display("FAIL reset_rd1 dut%0d: got %h expected 100", d, obs(d, 1));
            end
            checks++;
            if (obs(d, 2) !== 9'h100) begin
                errors++; $display("FAIL reset_rd2 dut%0d: got %h expected 100", d, obs(d, 2));
            end
        end
    endtask

    task automatic test_basic_write();
        idle(); ra1 = 3'd1; ra2 = 3'd4;
        we3 = 1; wa3 = 3'd1; wd3 = 8'hAB;
        #1;
        checks++;
        if (obs(1, 1) !== 9'h1AB) begin
            errors++; $display("FAIL basic_bypass dut1: got %h expected 1ab", obs(1, 1));
        end
        checks++;
        if (obs(0, 1) !== 9'h100) begin
            errors++; $display("FAIL basic_nobypass dut0: got %h expected 100", obs(0, 1));
        end
        tick();
        wa3 = 3'd4; wd3 = 8'hFF;
        #1;
        checks++;
        if (obs(0, 1) !== 9'h1AB) begin
            errors++; $display("FAIL basic_after_edge1 dut0: got %h expected 1ab", obs(0, 1));
        end
        checks++;
        if (obs(0, 2) !== 9'h100) begin
            errors++; $display("FAIL basic_rd2_pre dut0: got %h expected 100", obs(0, 2));
        end
        tick(); idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h1AB || obs(d, 2) !== 9'h1FF) begin
                errors++;
                $display("FAIL basic_after_edge2 dut%0d: got %h/%h expected 1ab/1ff", d, obs(d, 1), obs(d, 2));
            end
        end
    endtask

    task automatic test_dual_write();
        idle(); ra1 = 3'd5;
        we3 = 1; wa3 = 3'd5; wd3 = 8'h11;
        we4 = 1; wa4 = 3'd5; wd4 = 8'hAF;
        #1;
        checks++;
        if (obs(1, 1) !== 9'h1AF) begin
            errors++; $display("FAIL dual_bypass dut1: got %h expected 1af", obs(1, 1));
        end
        tick(); idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h1AF) begin
                errors++; $display("FAIL dual_stored dut%0d: got %h expected 1af", d, obs(d, 1));
            end
        end
    endtask

    task automatic test_scoreboard();
        idle(); ra1 = 3'd2; alloc = 1; aa = 3'd2;
        tick(); idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h000) begin
                errors++; $display("FAIL sb_pending dut%0d: got %h expected 000", d, obs(d, 1));
            end
        end
        tick(); tick();
        we3 = 1; wa3 = 3'd2; wd3 = 8'h5A;
        #1;
        checks++;
        if (obs(0, 1) !== 9'h000) begin
            errors++; $display("FAIL sb_still_pending dut0: got %h expected 000", obs(0, 1));
        end
        checks++;
        if (obs(1, 1) !== 9'h15A) begin
            errors++; $display("FAIL sb_bypass_ready dut1: got %h expected 15a", obs(1, 1));
        end
        tick(); idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h15A) begin
                errors++; $display("FAIL sb_written dut%0d: got %h expected 15a", d, obs(d, 1));
            end
        end
    endtask

    task automatic test_alloc_collision();
        idle(); ra1 = 3'd3;
        alloc = 1; aa = 3'd3; we4 = 1; wa4 = 3'd3; wd4 = 8'h77;
        #1;
        checks++;
        if (obs(1, 1) !== 9'h177) begin
            errors++; $display("FAIL coll_bypass dut1: got %h expected 177", obs(1, 1));
        end
        tick(); idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h077) begin
                errors++; $display("FAIL coll_after dut%0d: got %h expected 077", d, obs(d, 1));
            end
        end
    endtask

    task automatic test_zero_reg();
        idle(); ra1 = 3'd0;
        we3 = 1; wa3 = 3'd0; wd3 = 8'hFF; alloc = 1; aa = 3'd0;
        #1;
        checks++;
        if (obs(2, 1) !== 9'h100) begin
            errors++; $display("FAIL zero_same_cycle dut2: got %h expected 100", obs(2, 1));
        end
        checks++;
        if (obs(1, 1) !== 9'h1FF) begin
            errors++; $display("FAIL zero_nonzero_bypass dut1: got %h expected 1ff", obs(1, 1));
        end
        tick(); idle();
        #1;
        checks++;
        if (obs(2, 1) !== 9'h100) begin
            errors++; $display("FAIL zero_after dut2: got %h expected 100", obs(2, 1));
        end
        checks++;
        if (obs(0, 1) !== 9'h0FF) begin
            errors++; $display("FAIL zero_ordinary dut0: got %h expected 0ff", obs(0, 1));
        end
    endtask

    task automatic test_reset_priority();
        idle(); rst = 0; ra1 = 3'd3; ra2 = 3'd6;
        we4 = 1; wa4 = 3'd6; wd4 = 8'h3C;
        #1;
        checks++;
        if (obs(1, 2) !== 9'h13C) begin
            errors++; $display("FAIL rstprio_bypass dut1: got %h expected 13c", obs(1, 2));
        end
        checks++;
        if (obs(0, 1) !== 9'h077) begin
            errors++; $display("FAIL rstprio_pre dut0: got %h expected 077", obs(0, 1));
        end
        tick(); rst = 1; idle();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (obs(d, 1) !== 9'h100 || obs(d, 2) !== 9'h100) begin
                errors++;
                $display("FAIL rstprio_after dut%0d: got %h/%h expected 100/100", d, obs(d, 1), obs(d, 2));
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] exp;
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 39) != 0);
            ra1   = 3'($urandom_range(0, 7));
            ra2   = ($urandom_range(0, 7) == 0) ? ra1 : 3'($urandom_range(0, 7));
            we3   = 1'($urandom_range(0, 1));
            wa3   = 3'($urandom_range(0, 7));
            wd3   = 8'($urandom);
            we4   = 1'($urandom_range(0, 1));
            wa4   = ($urandom_range(0, 3) == 0) ? wa3 : 3'($urandom_range(0, 7));
            wd4   = 8'($urandom);
            alloc = ($urandom_range(0, 2) == 0);
            aa    = 3'($urandom_range(0, 7));
            #1;
            for (int d = 0; d < 3; d++) begin
                exp = exp_read(d, ra1);
                checks++;
                if (obs(d, 1) !== exp) begin
                    errors++; $display("FAIL rand_rd1 it%0d dut%0d: got %h expected %h", n, d, obs(d, 1), exp);
                end
                exp = exp_read(d, ra2);
                checks++;
                if (obs(d, 2) !== exp) begin
                    errors++; $display("FAIL rand_rd2 it%0d dut%0d: got %h expected %h", n, d, obs(d, 2), exp);
                end
            end
            tick();
        end
        rst = 1; idle();
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_dual_write();
        test_scoreboard();
        test_alloc_collision();
        test_zero_reg();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised successor to the 8-bit, 3-address register file used in the datapath. It provides N-bit registers addressed by M bits, two combinational read ports and two synchronous write ports with fixed priority. It adds an optional hardwired zero register, optional write-to-read bypass, and a per-register pending (scoreboard) bit, so the issue logic can stall on registers whose producer has not yet written back.

## Interface
Parameters:
- N, default 8: register data width in bits.
- M, default 3: address width; depth is 2**M registers.
- ZERO_REG, default 0: when 1, register 0 reads as 0 and is never written or marked pending.
- BYPASS, default 1: when 1, a read of an address being written in the current cycle returns the write data.

Ports (reset is synchronous and active-low; it acts only at a rising edge of clk):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- ra1  in  M  read address, port 1.
- ra2  in  M  read address, port 2.
- rd1  out  N  read data, port 1 (combinational).
- rd2  out  N  read data, port 2 (combinational).
- rdy1  out  1  1 when register ra1 is not pending.
- rdy2  out  1  1 when register ra2 is not pending.
- we3  in  1  write enable, port 3 (low priority).
- wa3  in  M  write address, port 3.
- wd3  in  N  write data, port 3.
- we4  in  1  write enable, port 4 (high priority).
- wa4  in  M  write address, port 4.
- wd4  in  N  write data, port 4.
- alloc  in  1  mark register aa as pending.
- aa  in  M  address to mark pending.

## Operation
State: register array R[0..2**M-1] of N bits each, and a pending vector P of 2**M bits.
- Reset: on a posedge with rst==0, all R become 0 and all P become 0. Reset overrides every write and alloc in that cycle.
- Write: on a posedge with rst==1:
  - we3 sets R[wa3] <= wd3 and clears P[wa3].
  - we4 sets R[wa4] <= wd4 and clears P[wa4].
  - Both enabled with wa3==wa4: wd4 is stored; port 3 is dropped.
- Alloc: on a posedge with rst==1 and alloc==1, P[aa] <= 1.
  - When alloc and a write target the same address in the same cycle, the data is stored and P stays 1, because the new producer supersedes the write.
- Read, BYPASS=0: rdX = R[raX] and rdyX = !P[raX].
- Read, BYPASS=1:
  - If we4 and wa4==raX: rdX = wd4 and rdyX = 1.
  - Otherwise, if we3 and wa3==raX: rdX = wd3 and rdyX = 1.
  - Otherwise, the BYPASS=0 rule applies.
  - A same-cycle alloc does not affect the bypassed rdy; the alloc is visible from the next cycle.
- ZERO_REG=1:
  - Reads of address 0 return 0 with rdy=1, including when bypass would apply.
  - Writes to and allocs of address 0 are ignored.
- Both read ports are fully independent. ra1==ra2 is legal, and both ports return identical values.
- The address range is exactly 2**M, so no out-of-range address exists.

## Timing
- Write latency: data is visible on rd from the cycle after the write edge (BYPASS=0), or in the same cycle combinationally (BYPASS=1).
- Pending latency: alloc at edge k makes rdy=0 from after edge k. A write at edge j>k makes rdy=1 after edge j, or combinationally in the write cycle when BYPASS=1.
- Output values after a reset edge:
  - rd1 = rd2 = 0 and rdy1 = rdy2 = 1, unless a bypass applies in the following cycle.
- While rst is held low, outputs follow the read rules against the cleared state, plus bypass of the incoming write data. The writes themselves are not committed.
- No internal FSM. Per-register state is held in R and P only.

## Test plan
- Reset then read: hold rst=0 for 2 edges, release, read ra1=1 and ra2=7 -> rd1=rd2=0x00, rdy1=rdy2=1.
- Basic write/read (BYPASS=0): we3=1, wa3=1, wd3=0xAB at edge 1; we3=1, wa3=4, wd3=0xFF at edge 2; set ra1=1, ra2=4 -> rd1=0xAB, rd2=0xFF from after edge 2.
- Dual-write conflict: we3=we4=1, wa3=wa4=5, wd3=0x11, wd4=0xAF -> R[5]=0xAF after the edge.
  - With BYPASS=1, a same-cycle read of ra1=5 also returns 0xAF.
- Scoreboard: alloc=1, aa=2 at edge k -> rdy(ra=2)=0 after edge k.
  - we3 to wa3=2 with 0x5A at edge k+3 -> rdy=1 and rd=0x5A after edge k+3.
  - With BYPASS=1, rdy=1 and rd=0x5A already combinationally during the cycle before edge k+3.
- Alloc/write collision: alloc=1, aa=3, we4=1, wa4=3, wd4=0x77 at the same edge -> R[3]=0x77 and rdy(3)=0 afterwards.
- ZERO_REG=1 and reset priority:
  - we3=1, wa3=0, wd3=0xFF and alloc to address 0 -> rd(0)=0, rdy(0)=1.
  - Separately, rst=0 with we4=1, wa4=6, wd4=0x3C at the same edge -> R[6]=0 after the edge.
